// File: rtl/array_allocator_if.sv
// rtl/array_allocator_if.sv - request/response bundle between a client and array_allocator
// Purpose: groups the allocator's alloc/free/write requests, size read port and status outputs.
// Ports (master drives requests, slave drives results):
//   alloc, free, free_handle          handle allocation and release requests
//   wr_en, wr_array, wr_index         element-write notification
//   size_array / size_out             combinational size read port
//   alloc_valid, alloc_handle, alloc_fail, err_free, err_write   registered one-cycle results
//   live_count, high_water            registered occupancy counters
interface array_allocator_if #(
  parameter int MemoryElementWidth = 12
);
  logic                          alloc;
  logic                          free;
  logic [MemoryElementWidth-1:0] free_handle;
  logic                          wr_en;
  logic [MemoryElementWidth-1:0] wr_array;
  logic [MemoryElementWidth-1:0] wr_index;
  logic [MemoryElementWidth-1:0] size_array;
  logic [MemoryElementWidth-1:0] size_out;
  logic                          alloc_valid;
  logic [MemoryElementWidth-1:0] alloc_handle;
  logic                          alloc_fail;
  logic                          err_free;
  logic                          err_write;
  logic [MemoryElementWidth-1:0] live_count;
  logic [MemoryElementWidth-1:0] high_water;

  modport master (
    output alloc, free, free_handle, wr_en, wr_array, wr_index, size_array,
    input  size_out, alloc_valid, alloc_handle, alloc_fail, err_free, err_write,
           live_count, high_water
  );

  modport slave (
    input  alloc, free, free_handle, wr_en, wr_array, wr_index, size_array,
    output size_out, alloc_valid, alloc_handle, alloc_fail, err_free, err_write,
           live_count, high_water
  );
endinterface

// File: rtl/array_allocator.sv
// rtl/array_allocator.sv - array handle allocator with LIFO free stack and per-array size table
// Purpose: grants array handles (recycled handles first, LIFO), tracks each array's logical
// length from element writes and serves the size table to the array instruction units.
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous active-low reset
//   bus    array_allocator_if.slave (requests in, registered results and combinational size_out)
module array_allocator #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 4,
  parameter int NArea              = 3
) (
  input logic               clock,
  input logic               reset,
  array_allocator_if.slave  bus
);
  localparam int W  = MemoryElementWidth;
  localparam int IW = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam logic [W-1:0] N_ARR  = W'(NArrays);
  localparam logic [W-1:0] N_AREA = W'(NArea);

  logic [NArrays-1:0] in_use;
  logic [W-1:0]       sizes [NArrays];
  logic [W-1:0]       stack [NArrays];
  logic [W-1:0]       top;
  logic [W-1:0]       counter;
  logic [W-1:0]       live;

  logic [IW-1:0] f_idx, w_idx, s_idx, pop_idx, push_idx, g_idx;
  logic          free_ok, have_stack, have_new, grant, wr_ok, grow;
  logic [W-1:0]  grant_h;

  // Index slices are only used after the corresponding range check passes.
  assign f_idx    = bus.free_handle[IW-1:0];
  assign w_idx    = bus.wr_array[IW-1:0];
  assign s_idx    = bus.size_array[IW-1:0];
  assign pop_idx  = IW'(top - W'(1));
  assign push_idx = IW'(top);

  assign free_ok    = bus.free && (bus.free_handle < N_ARR) && in_use[f_idx];
  assign have_stack = (top != '0);
  assign have_new   = (counter < N_ARR);
  // A legal same-cycle free feeds the alloc directly, so that alloc can never fail.
  assign grant      = bus.alloc && (free_ok || have_stack || have_new);
  assign grant_h    = free_ok    ? bus.free_handle :
                      have_stack ? stack[pop_idx]  : counter;
  assign g_idx      = IW'(grant_h);

  // Legality uses in_use as of the start of the cycle; writes racing a free or a grant of
  // the same handle are rejected.
  assign wr_ok = bus.wr_en && (bus.wr_array < N_ARR) && in_use[w_idx]
              && !(free_ok && (bus.free_handle == bus.wr_array))
              && !(grant && (grant_h == bus.wr_array))
              && (bus.wr_index < N_AREA);
  // Compare one bit wider so wr_index+1 cannot wrap.
  assign grow  = ({1'b0, bus.wr_index} + (W+1)'(1)) > {1'b0, sizes[w_idx]};

  // A freed handle keeps its stale size but must read as 0.
  assign bus.size_out   = ((bus.size_array < N_ARR) && in_use[s_idx]) ? sizes[s_idx] : '0;
  assign bus.live_count = live;
  assign bus.high_water = counter;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.alloc_valid  <= 1'b0;
      bus.alloc_handle <= '0;
      bus.alloc_fail   <= 1'b0;
      bus.err_free     <= 1'b0;
      bus.err_write    <= 1'b0;
      in_use           <= '0;
      top              <= '0;
      counter          <= '0;
      live             <= '0;
      for (int i = 0; i < NArrays; i++) begin
        sizes[i] <= '0;
        stack[i] <= '0;
      end
    end else begin
      bus.alloc_valid <= grant;
      bus.alloc_fail  <= bus.alloc && !grant;
      bus.err_free    <= bus.free && !free_ok;
      bus.err_write   <= bus.wr_en && !wr_ok;

      if (grant) begin
        bus.alloc_handle <= grant_h;
        in_use[g_idx]    <= 1'b1;
        sizes[g_idx]     <= '0;
        // Bypassed grants leave stack, counter and live untouched.
        if (!free_ok) begin
          if (have_stack) top <= top - W'(1);
          else            counter <= counter + W'(1);
          live <= live + W'(1);
        end
      end

      if (free_ok && !bus.alloc) begin
        in_use[f_idx]   <= 1'b0;
        stack[push_idx] <= bus.free_handle;
        top             <= top + W'(1);
        live            <= live - W'(1);
      end

      if (wr_ok && grow) sizes[w_idx] <= bus.wr_index + W'(1);
    end
  end
endmodule
